// File: rtl/i2s_tx.sv
// i2s_tx: I2S serial-data transmitter with a one-pair sample buffer.
// ck/rst_n clock+async reset; en/frame_posn slot timing; left/right/
// in_valid/in_ready sample handshake; sd serial out; underrun pulse,
// underrun_count (saturating); locked while frames are being sent.
module i2s_tx #(
  parameter int BITS    = 16,
  parameter int TIMEOUT = 64
) (
  input  logic            ck,
  input  logic            rst_n,
  input  logic            en,
  input  logic [5:0]      frame_posn,
  input  logic [BITS-1:0] left,
  input  logic [BITS-1:0] right,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            sd,
  output logic            underrun,
  output logic [7:0]      underrun_count,
  output logic            locked
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_RUN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic            buf_full;
  logic [BITS-1:0] buf_l;
  logic [BITS-1:0] buf_r;
  logic [BITS-1:0] sh_l;
  logic [BITS-1:0] sh_r;
  logic [TW-1:0]   tmo_q;

  logic [5:0] n;
  logic       accept;
  logic       load;
  logic       tmo_hit;
  logic       slot_bit;

  assign in_ready = !buf_full;
  assign accept   = in_valid && in_ready;
  assign locked   = (state_q == S_RUN);
  assign n        = frame_posn + 6'd1;

  assign load = en && (frame_posn == 6'd63)
             && (state_q != S_IDLE);

  // Fires on the TIMEOUT-th consecutive ck without en.
  assign tmo_hit = !en && (tmo_q == TW'(TIMEOUT - 1));

  // Slot map is indexed by the upcoming slot, so a
  // jump in frame_posn is followed without resync.
  always_comb begin
    slot_bit = 1'b0;
    for (int i = 0; i < BITS; i++) begin
      if (n == 6'(BITS - i))
        slot_bit = sh_l[i];
      if (n == 6'(32 + BITS - i))
        slot_bit = sh_r[i];
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      tmo_hit:
        state_d = S_IDLE;
      (state_q == S_IDLE) && en:
        state_d = S_SYNC;
      (state_q == S_SYNC) && load:
        state_d = S_RUN;
      default: ;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)
      tmo_q <= '0;
    else if (en)
      tmo_q <= '0;
    else if (tmo_q != TW'(TIMEOUT))
      tmo_q <= tmo_q + TW'(1);
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)
      sd <= 1'b0;
    else if (tmo_hit)
      sd <= 1'b0;
    else if (en)
      sd <= (state_q == S_RUN) ? slot_bit : 1'b0;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      sh_l <= '0;
      sh_r <= '0;
    end else if (tmo_hit) begin
      sh_l <= '0;
      sh_r <= '0;
    end else if (load) begin
      sh_l <= buf_full ? buf_l : '0;
      sh_r <= buf_full ? buf_r : '0;
    end
  end

  // A pair accepted on an empty-buffer load edge is
  // held for the following frame, never bypassed.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      buf_full <= 1'b0;
      buf_l    <= '0;
      buf_r    <= '0;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_l    <= left;
      buf_r    <= right;
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      underrun <= load && !buf_full;
      if (load && !buf_full
          && underrun_count != 8'hFF)
        underrun_count <= underrun_count + 8'd1;
    end
  end

endmodule
